// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues one instruction-memory request at a time and
// holds the returned word in a one-entry buffer for decode.
module fetch_sequencer #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            halt_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            misaligned_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StHold} state_e;

    state_e          r_state, w_state_next;
    logic [XLEN-1:0] r_next_pc, w_next_pc_next;
    logic [XLEN-1:0] r_fetch_addr, w_fetch_addr_next;
    logic            r_kill, w_kill_next;
    logic [31:0]     r_instr, w_instr_next;
    logic [XLEN-1:0] r_instr_pc, w_instr_pc_next;
    logic            r_misaligned;

    logic            w_event;
    logic [XLEN-1:0] w_raw_target;
    logic [XLEN-1:0] w_target;
    logic [XLEN-1:0] w_seq_pc;

    assign w_event      = trap_i | redirect_i;
    assign w_raw_target = trap_i ? trap_vec_i : redirect_pc_i;
    assign w_target     = {w_raw_target[XLEN-1:2], 2'b00};
    assign w_seq_pc     = r_fetch_addr + XLEN'(4);

    always_comb begin
        w_state_next      = r_state;
        w_next_pc_next    = r_next_pc;
        w_fetch_addr_next = r_fetch_addr;
        w_kill_next       = r_kill;
        w_instr_next      = r_instr;
        w_instr_pc_next   = r_instr_pc;
        unique case (r_state)
            StIdle: begin
                if (!halt_i) begin
                    w_fetch_addr_next = w_event ? w_target : r_next_pc;
                    w_state_next      = StReq;
                end else if (w_event) begin
                    w_next_pc_next = w_target;
                end
            end
            StReq: begin
                if (w_event) begin
                    w_next_pc_next = w_target;
                    w_kill_next    = 1'b1;
                end else if (imem_gnt_i && !r_kill) begin
                    // A pending kill already parked the redirect target in next_pc.
                    w_next_pc_next = w_seq_pc;
                end
                if (imem_gnt_i) begin
                    w_state_next = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid_i) begin
                    if (r_kill || w_event) begin
                        w_kill_next = 1'b0;
                        if (w_event) begin
                            w_next_pc_next = w_target;
                        end
                        if (halt_i) begin
                            w_state_next = StIdle;
                        end else begin
                            w_state_next      = StReq;
                            w_fetch_addr_next = w_event ? w_target : r_next_pc;
                        end
                    end else begin
                        w_instr_next    = imem_rdata_i;
                        w_instr_pc_next = r_fetch_addr;
                        w_state_next    = StHold;
                    end
                end else if (w_event) begin
                    w_next_pc_next = w_target;
                    w_kill_next    = 1'b1;
                end
            end
            StHold: begin
                if (w_event) begin
                    if (halt_i) begin
                        w_state_next   = StIdle;
                        w_next_pc_next = w_target;
                    end else begin
                        w_state_next      = StReq;
                        w_fetch_addr_next = w_target;
                    end
                end else if (instr_ready_i) begin
                    if (halt_i) begin
                        w_state_next = StIdle;
                    end else begin
                        w_state_next      = StReq;
                        w_fetch_addr_next = r_next_pc;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= StIdle;
            r_next_pc    <= RESET_ADDR;
            r_fetch_addr <= RESET_ADDR;
            r_kill       <= 1'b0;
            r_instr      <= '0;
            r_instr_pc   <= '0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_next_pc    <= w_next_pc_next;
            r_fetch_addr <= w_fetch_addr_next;
            r_kill       <= w_kill_next;
            r_instr      <= w_instr_next;
            r_instr_pc   <= w_instr_pc_next;
            r_misaligned <= w_event && (w_raw_target[1:0] != 2'b00);
        end
    end

    assign imem_req_o    = (r_state == StReq);
    assign imem_addr_o   = r_fetch_addr;
    // A same-cycle redirect masks the buffered word so decode never takes a stale one.
    assign instr_valid_o = (r_state == StHold) && !w_event;
    assign instr_o       = r_instr;
    assign instr_pc_o    = r_instr_pc;
    assign misaligned_o  = r_misaligned;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: random memory latency/grants, redirects, traps and halts,
// checked against a PC-stream model through a scoreboard queue.
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        trap_i = 1'b0;
    logic [31:0] trap_vec_i = '0;
    logic        misaligned_o;

    fetch_sequencer #(.XLEN(32), .RESET_ADDR(RESET_ADDR)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .halt_i       (halt_i),
        .imem_req_o   (imem_req_o),
        .imem_addr_o  (imem_addr_o),
        .imem_gnt_i   (imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i (imem_rdata_i),
        .instr_valid_o(instr_valid_o),
        .instr_o      (instr_o),
        .instr_pc_o   (instr_pc_o),
        .instr_ready_i(instr_ready_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .trap_i       (trap_i),
        .trap_vec_i   (trap_vec_i),
        .misaligned_o (misaligned_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          hs_count = 0;
    int          last_hs = 0;
    int          hs_cyc[$];
    logic [31:0] exp_q[$];
    bit          zero_wait = 1'b0;
    bit          stall_gnt = 1'b0;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0100;
            1:       return 32'h8000_0102;
            2:       return 32'h8000_0200;
            3:       return 32'hFFFF_FFFC;
            4:       return 32'hFFFF_FFF8;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // The next instruction decode sees is at the (aligned) target of the latest event.
    task automatic issue_event(input logic tr, input logic [31:0] tv,
                               input logic rd, input logic [31:0] rp);
        logic [31:0] t;
        trap_i        = tr;
        trap_vec_i    = tv;
        redirect_i    = rd;
        redirect_pc_i = rp;
        if (tr || rd) begin
            t = tr ? tv : rp;
            exp_q.delete();
            exp_q.push_back({t[31:2], 2'b00});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"}, {31'b0, imem_req_o}, 32'd0);
        chk({tag, "_addr"}, imem_addr_o, RESET_ADDR);
        chk({tag, "_valid"}, {31'b0, instr_valid_o}, 32'd0);
        chk({tag, "_instr"}, instr_o, 32'd0);
        chk({tag, "_pc"}, instr_pc_o, 32'd0);
        chk({tag, "_mis"}, {31'b0, misaligned_o}, 32'd0);
    endtask

    // Memory: one outstanding request, grant after random delay, response 1..3 cycles later.
    initial begin
        int          m_cnt;
        logic [31:0] m_addr;
        logic        prev_stall;
        logic [31:0] prev_addr;
        m_cnt      = 0;
        m_addr     = '0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                m_cnt         = 0;
                imem_gnt_i    = 1'b0;
                imem_rvalid_i = 1'b0;
                prev_stall    = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("req_held", {31'b0, imem_req_o}, 32'd1);
                    chk("addr_held", imem_addr_o, prev_addr);
                end
                imem_rvalid_i = 1'b0;
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        imem_rvalid_i = 1'b1;
                        imem_rdata_i  = mem_word(m_addr);
                    end
                end
                imem_gnt_i = 1'b0;
                if (imem_req_o && m_cnt == 0 && !imem_rvalid_i && !stall_gnt)
                    imem_gnt_i = zero_wait || ($urandom_range(0, 9) < 7);
                if (imem_gnt_i) begin
                    m_addr = imem_addr_o;
                    m_cnt  = zero_wait ? 1 : int'($urandom_range(1, 3));
                end
                prev_stall = imem_req_o && !imem_gnt_i;
                prev_addr  = imem_addr_o;
            end
        end
    end

    // Monitor: pops the scoreboard on every decode handshake.
    initial begin
        logic        exp_mis;
        logic        prev_wait;
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;
        logic        ev;
        logic [31:0] raw;
        logic [31:0] e;
        exp_mis   = 1'b0;
        prev_wait = 1'b0;
        prev_instr = '0;
        prev_pc    = '0;
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                ev  = trap_i || redirect_i;
                raw = trap_i ? trap_vec_i : redirect_pc_i;
                chk("misaligned", {31'b0, misaligned_o}, {31'b0, exp_mis});
                exp_mis = ev && (raw[1:0] != 2'b00);
                if (ev) chk("valid_masked", {31'b0, instr_valid_o}, 32'd0);
                if (prev_wait && !ev) begin
                    chk("hold_valid", {31'b0, instr_valid_o}, 32'd1);
                    chk("hold_instr", instr_o, prev_instr);
                    chk("hold_pc", instr_pc_o, prev_pc);
                    chk("hold_no_req", {31'b0, imem_req_o}, 32'd0);
                end
                if (instr_valid_o && instr_ready_i) begin
                    hs_count++;
                    hs_cyc.push_back(cyc);
                    last_hs = cyc;
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_empty: got pc %h, expected no instruction", instr_pc_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("instr_pc", instr_pc_o, e);
                        chk("instr_word", instr_o, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                    end
                end
                if (!halt_i && (cyc - last_hs) > 300) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL progress: got no handshake for %0d cycles, expected <= 300",
                             cyc - last_hs);
                    last_hs = cyc;
                end
                prev_wait  = instr_valid_o && !instr_ready_i;
                prev_instr = instr_o;
                prev_pc    = instr_pc_o;
            end else begin
                prev_wait = 1'b0;
                exp_mis   = 1'b0;
            end
        end
    end

    initial begin
        bit found;
        #12;
        check_reset_outputs("reset");

        // Zero-wait memory, decode always ready: one instruction every 3 cycles.
        zero_wait     = 1'b1;
        instr_ready_i = 1'b1;
        exp_q.push_back(RESET_ADDR);
        @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        last_hs = cyc;
        repeat (10) @(posedge clk);
        #1;
        if (hs_cyc.size() >= 3) begin
            chk("rate_1", hs_cyc[1] - hs_cyc[0], 32'd3);
            chk("rate_2", hs_cyc[2] - hs_cyc[1], 32'd3);
        end else begin
            n_tests++;
            n_fail++;
            $display("FAIL rate: got %0d handshakes, expected >= 3", hs_cyc.size());
        end

        // Grant withheld with a redirect mid-stall.
        stall_gnt = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            found = imem_req_o;
        end
        chk("stall_req_seen", {31'b0, found}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b1, 32'h8000_0100);
        @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        stall_gnt = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        // Trap and redirect together: trap wins.
        issue_event(1'b1, 32'h8000_0200, 1'b1, 32'h8000_0100);
        @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b0, '0);
        repeat (12) @(posedge clk);
        #1;

        // Halt: buffered word is taken, then no further request.
        halt_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("halt_no_req", {31'b0, imem_req_o}, 32'd0);
        chk("halt_no_valid", {31'b0, instr_valid_o}, 32'd0);
        halt_i = 1'b0;

        // Misaligned target, then sequential wrap past the top of the address space.
        issue_event(1'b0, '0, 1'b1, 32'h8000_0102);
        @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b0, '0);
        repeat (10) @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b1, 32'hFFFF_FFF8);
        @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b0, '0);
        repeat (15) @(posedge clk);

        // Random traffic.
        zero_wait = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            instr_ready_i = ($urandom_range(0, 9) < 7);
            if (halt_i) halt_i = ($urandom_range(0, 9) != 0);
            else        halt_i = ($urandom_range(0, 99) == 0);
            issue_event($urandom_range(0, 99) < 3, pick_target(),
                        $urandom_range(0, 99) < 5, pick_target());
        end
        @(posedge clk);
        #1;
        issue_event(1'b0, '0, 1'b0, '0);
        halt_i        = 1'b0;
        instr_ready_i = 1'b1;
        repeat (20) @(posedge clk);
        chk("progress", {31'b0, hs_count > 100}, 32'd1);

        // Asynchronous reset while a response is outstanding.
        zero_wait = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(posedge clk);
            #2;
            found = imem_req_o && imem_gnt_i;
        end
        chk("wait_reached", {31'b0, found}, 32'd1);
        @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_reset_outputs("async_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
